alu_share_arb: RTL

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

---
 rtl/alu_share_arb_pkg.sv | 19 +
 rtl/alu_share_core.sv | 33 +++
 rtl/alu_share_arb.sv | 133 +++++++++++++
 3 files changed

// File: rtl/alu_share_arb_pkg.sv
// Shared op-code constants and FSM state type for the two-requester shared ALU.
package alu_share_arb_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_core.sv
// Combinational ALU evaluated on the arbiter's captured operands.
module alu_share_core
  import alu_share_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [4:0]       shamt,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  always_comb begin
    // NOTE: default assigned first so every path drives result; no latch is inferred.
    result = '0;
    case (ctrl)
      OP_AND:  result = in1 & in2;
      OP_OR:   result = in1 | in2;
      OP_ADD:  result = in1 + in2;
      OP_SUB:  result = in1 - in2;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      OP_NOR:  result = ~(in1 | in2);
      OP_SLL:  result = in1 << shamt;
      OP_SRL:  result = in1 >> shamt;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arb.sv
// Two-requester arbiter sharing one ALU: IDLE -> EXEC -> RESP handshake FSM.
// Build option: define ALU_SHARE_ARB_FIXED_PRIO_EN for fixed priority to requester 0.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_ctrl,
  input  logic [WIDTH-1:0] req0_in1,
  input  logic [WIDTH-1:0] req0_in2,
  input  logic [4:0]       req0_shamt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_ctrl,
  input  logic [WIDTH-1:0] req1_in1,
  input  logic [WIDTH-1:0] req1_in2,
  input  logic [4:0]       req1_shamt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] in1_q, in1_d, in2_q, in2_d;
  logic [4:0]       shamt_q, shamt_d;
  logic             id_q, id_d;
  logic             rsp_id_q, rsp_id_d, rsp_zero_q, rsp_zero_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             grant_id, tie_pick, accept;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

`ifdef ALU_SHARE_ARB_FIXED_PRIO_EN
  assign tie_pick = 1'b0;
`else
  // last_q holds the most recently granted requester; the other one wins a tie.
  logic last_q, last_d;
  assign tie_pick = ~last_q;
  assign last_d   = (state_q == IDLE && accept) ? grant_id : last_q;

  always_ff @(posedge clk) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`endif

  always_comb begin
    grant_id = req1_valid & ~req0_valid;
    if (req0_valid && req1_valid) grant_id = tie_pick;
  end

  assign req0_ready = (state_q == IDLE) & ~reset & req0_valid & ~grant_id;
  assign req1_ready = (state_q == IDLE) & ~reset & req1_valid & grant_id;
  assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  alu_share_core #(.WIDTH(WIDTH)) u_core (
    .ctrl   (ctrl_q),
    .in1    (in1_q),
    .in2    (in2_q),
    .shamt  (shamt_q),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_comb begin
    state_d      = state_q;
    ctrl_d       = ctrl_q;
    in1_d        = in1_q;
    in2_d        = in2_q;
    shamt_d      = shamt_q;
    id_d         = id_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = EXEC;
        ctrl_d  = grant_id ? req1_ctrl  : req0_ctrl;
        in1_d   = grant_id ? req1_in1   : req0_in1;
        in2_d   = grant_id ? req1_in2   : req0_in2;
        shamt_d = grant_id ? req1_shamt : req0_shamt;
        id_d    = grant_id;
      end
      EXEC: begin
        state_d      = RESP;
        rsp_id_d     = id_q;
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments in clocked blocks so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  // NOTE: captured operands are data-only and always written before use, so they carry no reset.
  always_ff @(posedge clk) begin
    ctrl_q  <= ctrl_d;
    in1_q   <= in1_d;
    in2_q   <= in2_d;
    shamt_q <= shamt_d;
    id_q    <= id_d;
  end

  assign rsp_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;

endmodule
